hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Pipeline control block for the non-forwarding MIPS-lite pipeline.
- Tracks in-flight destination registers across the EX, MEM and WB slots in a 3-entry scoreboard.
- Stalls IF/ID on read-after-write hazards, flushes IF/ID when the execute stage reports a taken branch or jump, and sequences halt drain.
- Sits beside the decode stage. Drives PC hold, IF/ID flush and ID/EX bubble insertion. Also keeps performance counters.

Parameters:
- REG_WIDTH, 5, register index width (32 architectural registers).
- CNT_WIDTH, 32, width of each performance counter.
- WB_WRITE_THROUGH, 1, 1 = register file writes before reads in the same cycle, so the WB slot is never a hazard; 0 = the WB slot is also compared.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_WIDTH  rs index of the ID instruction.
- id_src1_used  in  1  instruction reads rs.
- id_src2  in  REG_WIDTH  rt index of the ID instruction.
- id_src2_used  in  1  instruction reads rt (R-type, store, BEQ).
- id_dest  in  REG_WIDTH  destination index.
- id_writes  in  1  instruction writes the register file.
- id_halt  in  1  ID instruction is HALT.
- ex_is_taken  in  1  taken branch/jump from execute (combinational, same cycle).
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX this edge.
- flush_if_id  out  1  clear IF/ID this edge.
- halted  out  1  pipeline drained after HALT.
- stall_count  out  CNT_WIDTH  cycles stalled due to hazards.
- flush_count  out  CNT_WIDTH  taken-branch flushes.
- retired_count  out  CNT_WIDTH  instructions leaving WB.

Behaviour:
- Scoreboard:
  - Slots ex, mem, wb, each {valid, writes, dest}. All are cleared on reset.
  - Every cycle the slots shift: wb<=mem, mem<=ex.
  - ex<={1, id_writes, id_dest} when issue=id_valid & ~stall & ~flush & state==RUN. Otherwise ex<=0 (bubble).
- Hazard:
  - A source src hazards when src_used and src!=0 and the source matches a slot with valid & writes & dest==src.
  - Slots compared: ex and mem. The wb slot is compared only when WB_WRITE_THROUGH=0.
  - The result is a maximum of 2 stall cycles (3 when WB_WRITE_THROUGH=0) behind a dependent producer.
- Taken branch:
  - Effective taken = ex_is_taken & ex.valid. ex_is_taken during an EX bubble is ignored.
- Priority: flush > stall.
  - On taken: flush_if_id=1, bubble_ex=1, stall_if_id=0. The ID instruction is squashed, including a HALT. No stall is counted.
  - Otherwise on hazard: stall_if_id=1, bubble_ex=1.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when a HALT issues (the HALT occupies the ex slot).
  - DRAIN: stall_if_id=1, bubble_ex=1, no issue. DRAIN -> HALTED when ex, mem and wb are all invalid at the clock edge.
  - HALTED: halted=1, stall_if_id=1, bubble_ex=1, flush_if_id=0. Only reset leaves HALTED.
  - ex_is_taken during DRAIN does not flush, because the HALT is the youngest instruction.
- Counters:
  - stall_count +1 per cycle in RUN with hazard & ~taken.
  - flush_count +1 per effective taken.
  - retired_count +1 per cycle with wb.valid; HALT itself counts.
  - Counters wrap modulo 2^CNT_WIDTH.
- Output timing: control outputs are combinational from the slots, the ID inputs and the state. Counters and halted are registered.
- Reset values: all outputs 0, state RUN, all slots invalid. Reset mid-drain returns to RUN with an empty scoreboard.

Decomposition:
- Shared package Types gains:
  - typedef SbSlot {valid, writes, dest}.
  - enum HazState {RUN, DRAIN, HALTED}.
  - Existing REG_WIDTH reused.
- Natural sub-module: hazard_scoreboard. It holds the three slots, handles the shift and bubble insertion, and provides a combinational match output. The FSM and counters stay in the top module.

Test Plan:
- ADD r3 issued, next ID reads r3 (src1_used), WB_WRITE_THROUGH=1 -> stall_if_id=1 for exactly 2 cycles, then issue. stall_count=2.
- Same sequence with WB_WRITE_THROUGH=0 -> 3 stall cycles. Independent consumer (reads r4) -> 0 stalls. Consumer reading r0 after a write to r0 -> 0 stalls.
- BEQ in EX with ex_is_taken=1 while ID holds a hazarding instruction -> flush_if_id=1, stall_if_id=0, flush_count=1, stall_count unchanged. The squashed instruction never reaches retired_count.
- HALT issued with 2 older instructions in flight -> DRAIN for 3 cycles, halted=1 on the following cycle, retired_count=3, stall_if_id held at 1.
- HALT in ID coinciding with a taken branch in EX -> HALT squashed, state stays RUN, fetch resumes.
- Reset asserted in DRAIN -> next cycle state RUN, all outputs 0, counters 0, and no stall against previously tracked destinations.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// Shared types for the hazard sequencer slice.
// REG_WIDTH : architectural register index width (32 registers).
// SbSlot    : one scoreboard entry {valid, writes, dest}.
// HazState  : sequencer control states.
// slot_hit  : does a used, non-zero source read the register a slot is producing?
package hazard_sequencer_pkg;

  localparam int unsigned REG_WIDTH = 5;

  typedef struct packed {
    logic                 valid;
    logic                 writes;
    logic [REG_WIDTH-1:0] dest;
  } SbSlot;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } HazState;

  // r0 is hardwired to zero, so it never carries a dependency.
  function automatic logic slot_hit(input SbSlot slot,
                                    input logic [REG_WIDTH-1:0] src,
                                    input logic used);
    return used && (src != '0) && slot.valid && slot.writes && (slot.dest == src);
  endfunction

endpackage

// File: rtl/hazard_sequencer_scoreboard.sv
// In-flight destination tracker for the EX, MEM and WB slots.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   issue               : ID instruction enters EX this edge (else a bubble)
//   issue_writes/dest   : write flag and destination of the issuing instruction
//   src1/src1_used      : first source of the ID instruction
//   src2/src2_used      : second source of the ID instruction
//   hazard              : some used source matches a producing slot
//   ex_valid            : EX slot holds a real instruction
//   wb_valid            : WB slot holds a real instruction (retiring this edge)
//   drain_done          : after this edge only WB could be occupied -> pipeline empty next
module hazard_scoreboard
  import hazard_sequencer_pkg::*;
#(
  parameter bit WB_WRITE_THROUGH = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue,
  input  logic                 issue_writes,
  input  logic [REG_WIDTH-1:0] issue_dest,
  input  logic [REG_WIDTH-1:0] src1,
  input  logic                 src1_used,
  input  logic [REG_WIDTH-1:0] src2,
  input  logic                 src2_used,
  output logic                 hazard,
  output logic                 ex_valid,
  output logic                 wb_valid,
  output logic                 drain_done
);

  SbSlot ex_slot;
  SbSlot mem_slot;
  SbSlot wb_slot;
  logic  wb_cmp;

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (issue) begin
        ex_slot <= '{valid: 1'b1, writes: issue_writes, dest: issue_dest};
      end else begin
        ex_slot <= '0;
      end
    end
  end

  // With a write-through register file the WB producer is already visible to decode.
  assign wb_cmp = ~WB_WRITE_THROUGH;

  always_comb begin
    hazard = slot_hit(ex_slot,  src1, src1_used) |
             slot_hit(mem_slot, src1, src1_used) |
             (wb_cmp & slot_hit(wb_slot, src1, src1_used)) |
             slot_hit(ex_slot,  src2, src2_used) |
             slot_hit(mem_slot, src2, src2_used) |
             (wb_cmp & slot_hit(wb_slot, src2, src2_used));
  end

  assign ex_valid = ex_slot.valid;
  assign wb_valid = wb_slot.valid;
  // No issue happens while draining, so once EX and MEM are empty the next edge empties all slots.
  assign drain_done = ~ex_slot.valid & ~mem_slot.valid;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control for the non-forwarding MIPS-lite pipeline.
// Stalls IF/ID on RAW hazards, flushes IF/ID on taken branches, drains on HALT
// and keeps performance counters.
// Ports:
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   id_*                      : decode-stage instruction description
//   ex_is_taken               : taken branch/jump resolved in EX this cycle
//   stall_if_id               : hold PC and IF/ID
//   bubble_ex                 : load a NOP into ID/EX
//   flush_if_id               : clear IF/ID
//   halted                    : pipeline drained after HALT (registered)
//   stall/flush/retired_count : wrapping performance counters (registered)
// REG_WIDTH must equal hazard_sequencer_pkg::REG_WIDTH (scoreboard slot width).
module hazard_sequencer #(
  parameter int unsigned REG_WIDTH        = 5,
  parameter int unsigned CNT_WIDTH        = 32,
  parameter bit          WB_WRITE_THROUGH = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_WIDTH-1:0] id_src1,
  input  logic                 id_src1_used,
  input  logic [REG_WIDTH-1:0] id_src2,
  input  logic                 id_src2_used,
  input  logic [REG_WIDTH-1:0] id_dest,
  input  logic                 id_writes,
  input  logic                 id_halt,
  input  logic                 ex_is_taken,
  output logic                 stall_if_id,
  output logic                 bubble_ex,
  output logic                 flush_if_id,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [CNT_WIDTH-1:0] retired_count
);

  import hazard_sequencer_pkg::HazState;
  import hazard_sequencer_pkg::RUN;
  import hazard_sequencer_pkg::DRAIN;
  import hazard_sequencer_pkg::HALTED;

  HazState state;
  HazState state_next;

  logic sb_hazard;
  logic ex_valid;
  logic wb_valid;
  logic drain_done;
  logic in_run;
  logic taken;
  logic hazard;
  logic issue;

  hazard_scoreboard #(
    .WB_WRITE_THROUGH(WB_WRITE_THROUGH)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .issue        (issue),
    .issue_writes (id_writes),
    .issue_dest   (id_dest),
    .src1         (id_src1),
    .src1_used    (id_src1_used),
    .src2         (id_src2),
    .src2_used    (id_src2_used),
    .hazard       (sb_hazard),
    .ex_valid     (ex_valid),
    .wb_valid     (wb_valid),
    .drain_done   (drain_done)
  );

  // A taken report against an EX bubble is stale; during DRAIN the HALT is youngest.
  always_comb begin
    in_run = (state == RUN);
    taken  = in_run & ex_is_taken & ex_valid;
    hazard = in_run & id_valid & sb_hazard;
    issue  = in_run & id_valid & ~taken & ~hazard;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (issue && id_halt) state_next = DRAIN;
      DRAIN:   if (drain_done)       state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    unique case (state)
      RUN: begin
        if (taken) begin
          flush_if_id = 1'b1;
          bubble_ex   = 1'b1;
        end else if (hazard) begin
          stall_if_id = 1'b1;
          bubble_ex   = 1'b1;
        end
      end
      DRAIN, HALTED: begin
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      halted        <= 1'b0;
      stall_count   <= '0;
      flush_count   <= '0;
      retired_count <= '0;
    end else begin
      halted        <= (state_next == HALTED);
      stall_count   <= stall_count   + CNT_WIDTH'(hazard & ~taken);
      flush_count   <= flush_count   + CNT_WIDTH'(taken);
      retired_count <= retired_count + CNT_WIDTH'(wb_valid);
    end
  end

endmodule
